// File: rtl/nes_oam_dma_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nes_oam_dma_if : CPU-side bus and DMA override signals of the OAM DMA unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface nes_oam_dma_if #(
  parameter int Dt_sz = 8,
  parameter int Ad_sz = 16
);
  logic [Ad_sz-1:0] cpu_addr;
  logic             cpu_r_bw;
  logic [Dt_sz-1:0] cpu_wdata;
  logic [Dt_sz-1:0] bus_rdata;
  logic             cpu_rdy;
  logic             dma_own;
  logic [Ad_sz-1:0] dma_addr;
  logic             dma_r_bw;
  logic [Dt_sz-1:0] dma_wdata;
  logic             dma_busy;

  modport master (
    output cpu_addr, cpu_r_bw, cpu_wdata, bus_rdata,
    input  cpu_rdy, dma_own, dma_addr, dma_r_bw, dma_wdata, dma_busy
  );

  modport slave (
    input  cpu_addr, cpu_r_bw, cpu_wdata, bus_rdata,
    output cpu_rdy, dma_own, dma_addr, dma_r_bw, dma_wdata, dma_busy
  );
endinterface
`default_nettype wire

// File: rtl/nes_oam_dma.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nes_oam_dma : halts the CPU and copies a 256-byte page into PPU OAM
// Rev 1.0
// ---------------------------------------------------------------------------
module nes_oam_dma #(
  parameter int               Dt_sz    = 8,
  parameter int               Ad_sz    = 16,
  parameter logic [Ad_sz-1:0] DMA_REG  = 16'h4014,
  parameter logic [Ad_sz-1:0] OAM_DATA = 16'h2004
) (
  input wire logic     NES_clk,
  input wire logic     NES_b_rst,
  nes_oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_par;
  logic [Dt_sz-1:0] r_page;
  logic [Dt_sz-1:0] r_data;
  logic [7:0]       r_idx;
  logic             w_trigger;

  // Only honoured in IDLE, so a retrigger mid-transfer cannot disturb the page
  assign w_trigger = (r_state == S_IDLE) && !bus.cpu_r_bw && (bus.cpu_addr == DMA_REG);

  always_ff @(posedge NES_clk or negedge NES_b_rst) begin
    if (!NES_b_rst) begin
      r_state <= S_IDLE;
      r_par   <= 1'b0;
      r_page  <= '0;
      r_data  <= '0;
      r_idx   <= 8'h00;
    end else begin
      r_state <= w_next;
      r_par   <= ~r_par;
      if (w_trigger) begin
        r_page <= bus.cpu_wdata;
        r_idx  <= 8'h00;
      end
      if (r_state == S_READ) begin
        r_data <= bus.bus_rdata;
      end
      if (r_state == S_WRITE) begin
        r_idx <= r_idx + 8'h01;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_next = S_HALT;
      // The 6502 ignores RDY on write cycles, so wait for a read before stealing the bus
      S_HALT:  if (bus.cpu_r_bw) w_next = r_par ? S_READ : S_ALIGN;
      S_ALIGN: w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_rdy   = (r_state == S_IDLE);
    bus.dma_busy  = (r_state != S_IDLE);
    bus.dma_own   = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_r_bw  = 1'b1;
    bus.dma_wdata = '0;
    if (r_state == S_READ) begin
      bus.dma_own  = 1'b1;
      bus.dma_addr = Ad_sz'({r_page, r_idx});
    end else if (r_state == S_WRITE) begin
      bus.dma_own   = 1'b1;
      bus.dma_addr  = OAM_DATA;
      bus.dma_r_bw  = 1'b0;
      bus.dma_wdata = r_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_oam_dma.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nes_oam_dma : randomized directed bench with a transfer-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_nes_oam_dma;

  localparam logic [15:0] C_DMA_REG  = 16'h4014;
  localparam logic [15:0] C_OAM_DATA = 16'h2004;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nes_oam_dma_if #(.Dt_sz(8), .Ad_sz(16)) bus ();

  nes_oam_dma dut (
    .NES_clk   (clk),
    .NES_b_rst (rst_n),
    .bus       (bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.bus_rdata = mem[bus.dma_addr];

  int tests    = 0;
  int fails    = 0;
  int edges    = 0;
  int halt_cnt = 0;
  int pre_own  = -1;
  int bad      = 0;
  logic [15:0] rd_q [$];
  logic [15:0] wa_q [$];
  logic [7:0]  wd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic rbw, input logic [7:0] wd);
    bus.cpu_addr  = a;
    bus.cpu_r_bw  = rbw;
    bus.cpu_wdata = wd;
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    do a = 16'($urandom); while (a == C_DMA_REG);
    return a;
  endfunction

  // One bus cycle: observe mid-cycle, then advance past the next rising edge
  task automatic tick();
    @(negedge clk);
    if (bus.dma_own && pre_own < 0) pre_own = halt_cnt;
    if (!bus.cpu_rdy) halt_cnt++;
    if (bus.cpu_rdy === bus.dma_busy) bad++;
    if (bus.dma_own) begin
      if (bus.dma_r_bw) rd_q.push_back(bus.dma_addr);
      else begin
        wa_q.push_back(bus.dma_addr);
        wd_q.push_back(bus.dma_wdata);
      end
    end else if (bus.dma_addr !== 16'h0000 || bus.dma_r_bw !== 1'b1 || bus.dma_wdata !== 8'h00) begin
      bad++;
    end
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic clear_obs();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    halt_cnt = 0;
    pre_own  = -1;
    bad      = 0;
  endtask

  // Full transfer: trigger, nwr halted CPU writes, then a read; compares against
  // the expected 256 read/write pairs and halt length derived from bus parity.
  task automatic run_xfer(input logic [7:0] pg, input int nwr, input bit want_par1,
                          input bit poke, input string tag);
    bit par_rd;
    bit done;
    int exp_pre;
    int zero_hits;
    drive(rnd_addr(), 1'b1, 8'h00);
    while (((edges + 1 + nwr) % 2) != int'(want_par1)) tick();
    clear_obs();
    drive(C_DMA_REG, 1'b0, pg);
    tick();
    for (int i = 0; i < nwr; i++) begin
      drive(rnd_addr(), 1'b0, 8'($urandom));
      tick();
    end
    par_rd  = ((edges % 2) == 1);
    exp_pre = 1 + nwr + (par_rd ? 0 : 1);
    drive(rnd_addr(), 1'b1, 8'h00);
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      if (poke && k == 100) drive(C_DMA_REG, 1'b0, ~pg);
      else if (poke && k == 101) drive(rnd_addr(), 1'b1, 8'h00);
      tick();
      if (bus.cpu_rdy) done = 1'b1;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " halt_len"}, 32'(halt_cnt), 32'(exp_pre + 512));
    chk({tag, " first_read_at"}, 32'(pre_own), 32'(exp_pre));
    chk({tag, " n_reads"}, 32'(rd_q.size()), 32'd256);
    chk({tag, " n_writes"}, 32'(wa_q.size()), 32'd256);
    chk({tag, " idle_outputs"}, 32'(bad), 32'd0);
    zero_hits = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] src;
      src = {pg, 8'(i)};
      if (i < rd_q.size()) begin
        chk({tag, " rd_addr"}, 32'(rd_q[i]), 32'(src));
        if (rd_q[i] == 16'h0000 && pg != 8'h00) zero_hits++;
      end
      if (i < wa_q.size()) begin
        chk({tag, " wr_addr"}, 32'(wa_q[i]), 32'(C_OAM_DATA));
        chk({tag, " wr_data"}, 32'(wd_q[i]), 32'(mem[src]));
      end
    end
    chk({tag, " no_zero_page_read"}, 32'(zero_hits), 32'd0);
  endtask

  initial begin
    bit rst_done;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i) ^ 8'hA5;

    drive(rnd_addr(), 1'b1, 8'h00);
    #2;
    chk("reset cpu_rdy",   32'(bus.cpu_rdy),   32'd1);
    chk("reset dma_own",   32'(bus.dma_own),   32'd0);
    chk("reset dma_busy",  32'(bus.dma_busy),  32'd0);
    chk("reset dma_addr",  32'(bus.dma_addr),  32'h0);
    chk("reset dma_r_bw",  32'(bus.dma_r_bw),  32'd1);
    chk("reset dma_wdata", 32'(bus.dma_wdata), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    edges = 0;

    run_xfer(8'h02, 0, 1'b1, 1'b0, "page02_par1");
    run_xfer(8'h02, 0, 1'b0, 1'b0, "page02_par0");
    run_xfer(8'($urandom), 2, 1'($urandom), 1'b0, "halt_writes");
    run_xfer(8'hFF, int'($urandom_range(0, 3)), 1'($urandom), 1'b0, "pageFF");
    run_xfer(8'($urandom), 1, 1'($urandom), 1'b1, "retrigger_ignored");

    // Abort a transfer with reset in the WRITE cycle of idx 8'h40
    clear_obs();
    drive(C_DMA_REG, 1'b0, 8'h33);
    tick();
    drive(rnd_addr(), 1'b1, 8'h00);
    rst_done = 1'b0;
    for (int k = 0; k < 600 && !rst_done; k++) begin
      tick();
      if (bus.dma_own && !bus.dma_r_bw && rd_q.size() == 65) rst_done = 1'b1;
    end
    chk("abort reached idx40", 32'(rst_done), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort cpu_rdy",   32'(bus.cpu_rdy),   32'd1);
    chk("abort dma_own",   32'(bus.dma_own),   32'd0);
    chk("abort dma_busy",  32'(bus.dma_busy),  32'd0);
    chk("abort dma_addr",  32'(bus.dma_addr),  32'h0);
    chk("abort dma_r_bw",  32'(bus.dma_r_bw),  32'd1);
    chk("abort dma_wdata", 32'(bus.dma_wdata), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    edges = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("abort writes", 32'(wa_q.size()), 32'd64);
    chk("abort reads",  32'(rd_q.size()), 32'd65);
    chk("abort idle rdy", 32'(bus.cpu_rdy), 32'd1);

    run_xfer(8'($urandom), 0, 1'($urandom), 1'b0, "after_abort");
    for (int r = 0; r < 2; r++) begin
      run_xfer(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
